// File: rtl/xadc_sweep_sequencer_if.sv
// DRP port between the XADC sweep sequencer (master) and the XADC primitive (slave).
// Pure wiring bundle: no latency, no state.
// The DRP slave answers each den with one drdy; the master never overlaps reads.
interface xadc_sweep_sequencer_if;
  logic        drp_den;
  logic        drp_dwe;
  logic [6:0]  drp_daddr;
  logic [15:0] drp_di;
  logic [15:0] drp_do;
  logic        drp_drdy;

  modport master (
    output drp_den, drp_dwe, drp_daddr, drp_di,
    input  drp_do, drp_drdy
  );

  modport slave (
    input  drp_den, drp_dwe, drp_daddr, drp_di,
    output drp_do, drp_drdy
  );
endinterface

// File: rtl/xadc_sweep_sequencer.sv
// Round-robin XADC VAUX sweeper; optional averaging via XADC_SWEEP_AVG_EN.
// ch_data updates one cycle after drdy; sweep starts are spaced sweep_period+1 cycles.
// One DRP read in flight at a time; a missing drdy is abandoned after DRP_TIMEOUT cycles.
module xadc_sweep_sequencer #(
  parameter int         NUM_CH       = 4,
  parameter logic [6:0] CH_BASE_ADDR = 7'h10,
  parameter int         DRP_TIMEOUT  = 64
) (
  input  logic                   S_AXI_ACLK,
  input  logic                   S_AXI_ARESETN,
  input  logic                   enable,
  input  logic [15:0]            sweep_period,
  input  logic [NUM_CH-1:0]      ch_mask,
  input  logic                   err_clr,
  xadc_sweep_sequencer_if.master drp,
  output logic [12*NUM_CH-1:0]   ch_data,
  output logic [NUM_CH-1:0]      ch_valid,
  output logic                   busy,
  output logic                   sweep_done,
  output logic                   timeout_err
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TMO_W = $clog2(DRP_TIMEOUT + 1);
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(DRP_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, WAIT_TICK, SCAN, ISSUE, WAIT_RDY, DONE} state_t;

  state_t                     state_q, state_d;
  logic [CH_W-1:0]            ch_q, ch_d;
  logic [15:0]                cnt_q, cnt_d;
  logic [TMO_W-1:0]           tmo_q, tmo_d;
  logic [NUM_CH-1:0][11:0]    data_q, data_d;
  logic [NUM_CH-1:0]          valid_q, valid_d;
  logic                       err_q, err_d;
  logic [11:0]                sample;
  logic                       unused_lsb;

  assign unused_lsb = ^drp.drp_do[3:0];

`ifdef XADC_SWEEP_AVG_EN
  logic [12:0] avg_sum;
  assign avg_sum = {1'b0, data_q[ch_q]} + {1'b0, drp.drp_do[15:4]} + 13'd1;
  assign sample  = valid_q[ch_q] ? avg_sum[12:1] : drp.drp_do[15:4];
`else
  assign sample  = drp.drp_do[15:4];
`endif

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q <= IDLE;
      ch_q    <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      data_q  <= '0;
      valid_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    data_d  = data_q;
    valid_d = valid_q;
    err_d   = err_q;

    if (err_clr) err_d = 1'b0;
    // The period counter is measured from sweep start, so it keeps running during the sweep.
    if (state_q != IDLE && cnt_q != 16'd0) cnt_d = cnt_q - 16'd1;

    unique case (state_q)
      IDLE: begin
        if (enable && (|ch_mask)) begin
          state_d = WAIT_TICK;
          cnt_d   = sweep_period;
        end
      end
      WAIT_TICK: begin
        if (!enable || !(|ch_mask)) begin
          state_d = IDLE;
        end else if (cnt_q == 16'd0) begin
          state_d = SCAN;
          ch_d    = '0;
          cnt_d   = sweep_period;
        end
      end
      SCAN: begin
        if (!enable)                state_d = IDLE;
        else if (ch_mask[ch_q])     state_d = ISSUE;
        else if (ch_q == LAST_CH)   state_d = DONE;
        else                        ch_d    = ch_q + CH_W'(1);
      end
      ISSUE: begin
        tmo_d   = '0;
        state_d = WAIT_RDY;
      end
      WAIT_RDY: begin
        if (drp.drp_drdy || tmo_q == TMO_LAST) begin
          if (drp.drp_drdy) begin
            data_d[ch_q]  = sample;
            valid_d[ch_q] = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          // A read in flight when enable drops still lands, but the sweep ends here.
          if (!enable)               state_d = IDLE;
          else if (ch_q == LAST_CH)  state_d = DONE;
          else begin
            ch_d    = ch_q + CH_W'(1);
            state_d = SCAN;
          end
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      DONE: begin
        state_d = enable ? WAIT_TICK : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign drp.drp_den   = (state_q == ISSUE);
  assign drp.drp_daddr = (state_q == ISSUE) ? (CH_BASE_ADDR + 7'(ch_q)) : 7'd0;
  assign drp.drp_dwe   = 1'b0;
  assign drp.drp_di    = 16'd0;

  assign ch_data     = data_q;
  assign ch_valid    = valid_q;
  assign busy        = (state_q == SCAN) || (state_q == ISSUE) || (state_q == WAIT_RDY);
  assign sweep_done  = (state_q == DONE);
  assign timeout_err = err_q;

endmodule

// File: tb/tb_xadc_sweep_sequencer.sv
// Directed bench for xadc_sweep_sequencer with a behavioural DRP slave answering 5 cycles after den.
module tb_xadc_sweep_sequencer;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [15:0] sweep_period;
  logic [3:0]  ch_mask;
  logic        err_clr;
  logic [47:0] ch_data;
  logic [3:0]  ch_valid;
  logic        busy;
  logic        sweep_done;
  logic        timeout_err;

  xadc_sweep_sequencer_if drp();

  xadc_sweep_sequencer dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESETN(rst_n),
    .enable       (enable),
    .sweep_period (sweep_period),
    .ch_mask      (ch_mask),
    .err_clr      (err_clr),
    .drp          (drp),
    .ch_data      (ch_data),
    .ch_valid     (ch_valid),
    .busy         (busy),
    .sweep_done   (sweep_done),
    .timeout_err  (timeout_err)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int done_cnt = 0;
  int overlap = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (sweep_done === 1'b1) done_cnt++;

  // DRP slave: answers 5 cycles after den unless the channel is muted.
  logic [15:0] rsp_tab [4];
  logic [3:0]  mute;
  logic [6:0]  addr_q [$];
  logic [6:0]  idx;
  bit          pend;
  int          wcnt;
  logic [15:0] pend_dat;

  initial begin
    drp.drp_drdy = 1'b0;
    drp.drp_do   = 16'd0;
    pend = 1'b0;
    wcnt = 0;
    mute = 4'b0000;
  end

  always @(negedge clk) begin
    drp.drp_drdy = 1'b0;
    if (pend) begin
      if (wcnt == 0) begin
        drp.drp_drdy = 1'b1;
        drp.drp_do   = pend_dat;
        pend         = 1'b0;
      end else begin
        wcnt--;
      end
    end
    if (drp.drp_den === 1'b1) begin
      if (pend) overlap++;
      addr_q.push_back(drp.drp_daddr);
      idx = drp.drp_daddr - 7'h10;
      if (!mute[idx[1:0]]) begin
        pend     = 1'b1;
        wcnt     = 4;
        pend_dat = rsp_tab[idx[1:0]];
      end
    end
  end

  task automatic wait_done(input int budget, output bit ok, output int at);
    ok = 1'b0;
    at = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sweep_done === 1'b1) begin
        ok = 1'b1;
        at = cyc;
        return;
      end
    end
  endtask

  task automatic wait_den(input logic [6:0] a, input int budget, output bit ok, output int at);
    ok = 1'b0;
    at = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (drp.drp_den === 1'b1 && drp.drp_daddr === a) begin
        ok = 1'b1;
        at = cyc;
        return;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    enable = 1'b0;
    err_clr = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    enable = 1'b0;
    sweep_period = 16'd0;
    ch_mask = 4'h0;
    err_clr = 1'b0;
    #1;
    n_vec++; if (drp.drp_den !== 1'b0) begin n_err++; $display("FAIL reset_den: got %b want 0", drp.drp_den); end
    n_vec++; if (drp.drp_daddr !== 7'h00) begin n_err++; $display("FAIL reset_daddr: got %h want 00", drp.drp_daddr); end
    n_vec++; if (drp.drp_dwe !== 1'b0 || drp.drp_di !== 16'h0) begin n_err++; $display("FAIL reset_dwe_di: got %b/%h want 0/0000", drp.drp_dwe, drp.drp_di); end
    n_vec++; if (ch_data !== 48'h0) begin n_err++; $display("FAIL reset_ch_data: got %h want 0", ch_data); end
    n_vec++; if (ch_valid !== 4'h0) begin n_err++; $display("FAIL reset_ch_valid: got %h want 0", ch_valid); end
    n_vec++; if ({busy, sweep_done, timeout_err} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b want 000", {busy, sweep_done, timeout_err}); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_full_sweep();
    bit ok;
    int c1, c2, c3, c4;
    for (int i = 0; i < 4; i++) rsp_tab[i] = 16'hABC0;
    addr_q.delete();
    sweep_period = 16'd100;
    ch_mask = 4'hF;
    enable = 1'b1;
    wait_done(400, ok, c1);
    n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL full_done1: got no sweep_done want pulse"); end
    n_vec++; if (addr_q.size() !== 4) begin n_err++; $display("FAIL full_den_count: got %0d want 4", addr_q.size()); end
    for (int i = 0; i < 4 && i < addr_q.size(); i++) begin
      n_vec++; if (addr_q[i] !== 7'h10 + 7'(i)) begin n_err++; $display("FAIL full_addr%0d: got %h want %h", i, addr_q[i], 7'h10 + 7'(i)); end
    end
    n_vec++; if (ch_data !== {4{12'hABC}}) begin n_err++; $display("FAIL full_ch_data: got %h want abcabcabcabc", ch_data); end
    n_vec++; if (ch_valid !== 4'hF) begin n_err++; $display("FAIL full_ch_valid: got %h want f", ch_valid); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL full_busy_in_done: got %b want 0", busy); end
    wait_done(400, ok, c2);
    n_vec++; if (ok !== 1'b1 || (c2 - c1) !== 101) begin n_err++; $display("FAIL full_spacing_p100: got %0d want 101", c2 - c1); end
    // Period change only applies from the next sweep start.
    sweep_period = 16'd0;
    wait_done(400, ok, c3);
    wait_done(400, ok, c4);
    n_vec++; if (ok !== 1'b1 || (c4 - c3) !== 30) begin n_err++; $display("FAIL full_spacing_p0: got %0d want 30", c4 - c3); end
    enable = 1'b0;
    repeat (40) @(negedge clk);
  endtask

  task automatic test_mask();
    bit ok;
    int c;
    do_reset();
    rsp_tab[0] = 16'h111F; rsp_tab[1] = 16'h2220; rsp_tab[2] = 16'h333A; rsp_tab[3] = 16'h4440;
    addr_q.delete();
    sweep_period = 16'd100;
    ch_mask = 4'b0101;
    enable = 1'b1;
    wait_done(400, ok, c);
    enable = 1'b0;
    n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL mask_done: got no sweep_done want pulse"); end
    n_vec++; if (addr_q.size() !== 2) begin n_err++; $display("FAIL mask_den_count: got %0d want 2", addr_q.size()); end
    else begin
      n_vec++; if (addr_q[0] !== 7'h10 || addr_q[1] !== 7'h12) begin n_err++; $display("FAIL mask_addrs: got %h,%h want 10,12", addr_q[0], addr_q[1]); end
    end
    n_vec++; if (ch_data !== {12'h000, 12'h333, 12'h000, 12'h111}) begin n_err++; $display("FAIL mask_ch_data: got %h want 000333000111", ch_data); end
    n_vec++; if (ch_valid !== 4'b0101) begin n_err++; $display("FAIL mask_ch_valid: got %b want 0101", ch_valid); end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_timeout();
    bit ok;
    int k, c;
    rsp_tab[0] = 16'h0550; rsp_tab[1] = 16'h0660; rsp_tab[2] = 16'h0770; rsp_tab[3] = 16'h0880;
    mute = 4'b0100;
    addr_q.delete();
    sweep_period = 16'd200;
    ch_mask = 4'hF;
    enable = 1'b1;
    wait_den(7'h12, 500, ok, k);
    n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL tmo_den2: got no den for 12 want den"); end
    repeat (64) @(negedge clk);
    n_vec++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL tmo_early: got %b want 0 at 64 cycles after den", timeout_err); end
    // err_clr lands on the same edge as the timeout; the timeout must win.
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    n_vec++; if (timeout_err !== 1'b1) begin n_err++; $display("FAIL tmo_flag: got %b want 1", timeout_err); end
    wait_done(300, ok, c);
    enable = 1'b0;
    mute = 4'b0000;
    n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL tmo_done: got no sweep_done want pulse"); end
    n_vec++; if (addr_q.size() !== 4) begin n_err++; $display("FAIL tmo_den_count: got %0d want 4", addr_q.size()); end
    n_vec++; if (ch_data[35:24] !== 12'h333) begin n_err++; $display("FAIL tmo_slot2_kept: got %h want 333", ch_data[35:24]); end
    n_vec++; if (ch_data[47:36] !== 12'h088 || ch_data[23:12] !== 12'h066) begin n_err++; $display("FAIL tmo_slots13: got %h/%h want 088/066", ch_data[47:36], ch_data[23:12]); end
    n_vec++; if (ch_valid !== 4'hF) begin n_err++; $display("FAIL tmo_ch_valid: got %h want f", ch_valid); end
    repeat (3) @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    n_vec++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL tmo_clear: got %b want 0", timeout_err); end
  endtask

  task automatic test_enable_drop();
    bit ok;
    int k, d0;
    do_reset();
    rsp_tab[0] = 16'h0120; rsp_tab[1] = 16'h0340; rsp_tab[2] = 16'h0560; rsp_tab[3] = 16'h0780;
    addr_q.delete();
    sweep_period = 16'd10;
    ch_mask = 4'hF;
    enable = 1'b1;
    d0 = done_cnt;
    wait_den(7'h11, 200, ok, k);
    enable = 1'b0;
    n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL drop_den1: got no den for 11 want den"); end
    repeat (30) @(negedge clk);
    n_vec++; if (addr_q.size() !== 2) begin n_err++; $display("FAIL drop_den_count: got %0d want 2", addr_q.size()); end
    n_vec++; if (ch_data[23:12] !== 12'h034 || ch_data[11:0] !== 12'h012) begin n_err++; $display("FAIL drop_slots01: got %h/%h want 034/012", ch_data[23:12], ch_data[11:0]); end
    n_vec++; if (ch_valid !== 4'b0011) begin n_err++; $display("FAIL drop_ch_valid: got %b want 0011", ch_valid); end
    n_vec++; if (done_cnt - d0 !== 0) begin n_err++; $display("FAIL drop_no_done: got %0d pulses want 0", done_cnt - d0); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL drop_busy: got %b want 0", busy); end
  endtask

  task automatic test_reset_mid_read();
    bit ok;
    int k;
    do_reset();
    rsp_tab[0] = 16'h0FF0;
    sweep_period = 16'd3;
    ch_mask = 4'hF;
    enable = 1'b1;
    wait_den(7'h10, 100, ok, k);
    repeat (2) @(negedge clk);
    n_vec++; if (ok !== 1'b1 || busy !== 1'b1) begin n_err++; $display("FAIL rmid_busy_before: got %b want 1", busy); end
    rst_n = 1'b0;
    enable = 1'b0;
    #1;
    n_vec++; if ({busy, drp.drp_den, sweep_done, timeout_err} !== 4'b0000 || ch_valid !== 4'h0) begin n_err++; $display("FAIL rmid_outputs: got %b/%h want 0000/0", {busy, drp.drp_den, sweep_done, timeout_err}, ch_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    n_vec++; if (ch_valid !== 4'h0 || ch_data !== 48'h0) begin n_err++; $display("FAIL rmid_late_drdy: got %h/%h want 0/0", ch_valid, ch_data); end
  endtask

  task automatic test_sample_update();
    bit ok;
    int c;
    logic [11:0] exp2;
`ifdef XADC_SWEEP_AVG_EN
    exp2 = 12'h102;
`else
    exp2 = 12'h103;
`endif
    do_reset();
    rsp_tab[0] = 16'h1005;
    sweep_period = 16'd0;
    ch_mask = 4'b0001;
    enable = 1'b1;
    wait_done(200, ok, c);
    rsp_tab[0] = 16'h1030;
    n_vec++; if (ok !== 1'b1 || ch_data[11:0] !== 12'h100) begin n_err++; $display("FAIL upd_first: got %h want 100", ch_data[11:0]); end
    wait_done(200, ok, c);
    enable = 1'b0;
    n_vec++; if (ok !== 1'b1 || ch_data[11:0] !== exp2) begin n_err++; $display("FAIL upd_second: got %h want %h", ch_data[11:0], exp2); end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_no_overlap();
    n_vec++; if (overlap !== 0) begin n_err++; $display("FAIL den_overlap: got %0d want 0", overlap); end
  endtask

  initial begin
    test_reset();
    test_full_sweep();
    test_mask();
    test_timeout();
    test_enable_drop();
    test_reset_mid_read();
    test_sample_update();
    test_no_overlap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
